// File: rtl/fast_pkg.sv
// Shared definitions for the FAST configuration packet parser: header codes,
// word type, packet type codes, FSM state encodings and payload field helpers.
package fast_pkg;

    localparam int FAST_W = 134;

    localparam logic [1:0] HDR_HEAD = 2'b01;
    localparam logic [1:0] HDR_BODY = 2'b11;
    localparam logic [1:0] HDR_TAIL = 2'b10;

    localparam logic [15:0] TYPE_SEL_DEF  = 16'h9001;
    localparam logic [15:0] TYPE_READ_DEF = 16'h9002;
    localparam logic [15:0] TYPE_TCM_DEF  = 16'h9003;

    typedef logic [FAST_W-1:0] fast_word_t;

    typedef enum logic [2:0] {
        RX_IDLE    = 3'd0,
        RX_META    = 3'd1,
        RX_TYPE    = 3'd2,
        RX_PAYLOAD = 3'd3,
        RX_DISCARD = 3'd4
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE = 3'd0,
        TX_WAIT = 3'd1,
        TX_HEAD = 3'd2,
        TX_META = 3'd3,
        TX_TYPE = 3'd4,
        TX_DATA = 3'd5
    } tx_state_t;

    typedef enum logic [1:0] {
        KIND_NONE = 2'd0,
        KIND_TCM  = 2'd1,
        KIND_SEL  = 2'd2,
        KIND_READ = 2'd3
    } pkt_kind_t;

    function automatic logic [1:0] fast_hdr(input fast_word_t w);
        return w[133:132];
    endfunction

    function automatic logic [15:0] fast_type(input fast_word_t w);
        return w[31:16];
    endfunction

    // Payload field A (address / select value)
    function automatic logic [31:0] fast_fa(input fast_word_t w);
        return w[47:16];
    endfunction

    // Payload field B (write data)
    function automatic logic [31:0] fast_fb(input fast_word_t w);
        return w[79:48];
    endfunction

endpackage

// File: rtl/fast_reply_tx.sv
// Reply transmitter: waits for the captured TCM read data, then emits the
// four-word FAST reply packet, one word per cycle, with registered outputs.
module fast_reply_tx
    import fast_pkg::*;
#(
    parameter int          TCM_AW    = 10,
    parameter logic [15:0] TYPE_READ = TYPE_READ_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_start,
    input  logic [TCM_AW-1:0] i_addr,
    input  logic              i_rd_have,
    input  logic [31:0]       i_rd_data,
    output logic              o_busy,
    output logic              o_valid,
    output logic [FAST_W-1:0] o_data
);

    tx_state_t         r_state;
    tx_state_t         w_next;
    logic [TCM_AW-1:0] r_addr;
    logic [31:0]       r_rdata;
    logic              r_valid;
    fast_word_t        r_data;
    fast_word_t        w_word;
    logic              w_valid;

    // Next-state decode and selection of the word to present in that state
    always_comb begin
        w_next  = r_state;
        w_word  = {FAST_W{1'b0}};
        w_valid = 1'b0;
        case (r_state)
            TX_IDLE: begin
                if (i_start) w_next = TX_WAIT;
                else         w_next = TX_IDLE;
            end
            TX_WAIT: begin
                if (i_rd_have) w_next = TX_HEAD;
                else           w_next = TX_WAIT;
            end
            TX_HEAD: w_next = TX_META;
            TX_META: w_next = TX_TYPE;
            TX_TYPE: w_next = TX_DATA;
            TX_DATA: w_next = TX_IDLE;
            default: w_next = TX_IDLE;
        endcase
        case (w_next)
            TX_HEAD: begin
                w_valid = 1'b1;
                w_word  = {HDR_HEAD, 4'b0000, 128'd0};
            end
            TX_META: begin
                w_valid = 1'b1;
                w_word  = {HDR_BODY, 4'b0000, 128'd0};
            end
            TX_TYPE: begin
                w_valid = 1'b1;
                w_word  = {HDR_BODY, 4'b0000, 96'd0, TYPE_READ, 16'd0};
            end
            TX_DATA: begin
                w_valid = 1'b1;
                w_word  = {HDR_TAIL, 4'b0000, 48'd0, r_rdata, 32'(r_addr), 16'd0};
            end
            default: begin
                w_valid = 1'b0;
                w_word  = {FAST_W{1'b0}};
            end
        endcase
    end

    // State register, request latches and registered reply outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= TX_IDLE;
            r_addr  <= {TCM_AW{1'b0}};
            r_rdata <= 32'd0;
            r_valid <= 1'b0;
            r_data  <= {FAST_W{1'b0}};
        end else begin
            r_state <= w_next;
            if (r_state == TX_IDLE && i_start) begin
                r_addr <= i_addr;
            end
            if (r_state == TX_WAIT && i_rd_have) begin
                r_rdata <= i_rd_data;
            end
            r_valid <= w_valid;
            r_data  <= w_word;
        end
    end

    assign o_busy  = (r_state != TX_IDLE);
    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/fast_conf_parser.sv
// FAST configuration packet receiver: packet framing FSM, TCM write path,
// select latch, read-request capture and statistics counters. Replies to
// read requests are formatted by fast_reply_tx.
module fast_conf_parser
    import fast_pkg::*;
#(
    parameter int          TCM_AW    = 10,
    parameter logic [15:0] TYPE_SEL  = TYPE_SEL_DEF,
    parameter logic [15:0] TYPE_READ = TYPE_READ_DEF,
    parameter logic [15:0] TYPE_TCM  = TYPE_TCM_DEF,
    parameter int          CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              data_in_valid,
    input  logic [FAST_W-1:0] data_in,
    output logic              data_out_valid,
    output logic [FAST_W-1:0] data_out,
    output logic              tcm_wr_en,
    output logic [TCM_AW-1:0] tcm_wr_addr,
    output logic [31:0]       tcm_wr_data,
    output logic              tcm_rd_en,
    output logic [TCM_AW-1:0] tcm_rd_addr,
    input  logic [31:0]       tcm_rd_data,
    output logic [31:0]       conf_sel,
    output logic              conf_sel_upd,
    output logic [CNT_W-1:0]  tcm_wr_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    rx_state_t         r_rx_state;
    rx_state_t         w_rx_next;
    pkt_kind_t         r_kind;
    pkt_kind_t         w_kind_new;
    logic              r_first;
    logic              r_wr_en;
    logic [TCM_AW-1:0] r_wr_addr;
    logic [31:0]       r_wr_data;
    logic              r_rd_en;
    logic              r_rd_en_d;
    logic [TCM_AW-1:0] r_rd_addr;
    logic [31:0]       r_rd_data;
    logic              r_rd_have;
    logic [31:0]       r_conf_sel;
    logic              r_sel_upd;
    logic [CNT_W-1:0]  r_wr_cnt;
    logic [CNT_W-1:0]  r_err_cnt;
    logic              r_tx_start;

    logic [1:0]        w_hdr;
    logic [15:0]       w_type;
    logic [31:0]       w_fa;
    logic [31:0]       w_fb;
    logic              w_hdr_err;
    logic              w_pay;
    logic              w_last;
    logic              w_enter_pay;
    logic              w_in_range;
    logic              w_wr_go;
    logic              w_range_err;
    logic              w_sel_go;
    logic              w_rd_go;
    logic              w_tx_busy;
    logic              w_reply_go;
    logic              w_reply_err;
    logic              w_err_any;
    logic              w_unused;

    assign w_hdr    = fast_hdr(data_in);
    assign w_type   = fast_type(data_in);
    assign w_fa     = fast_fa(data_in);
    assign w_fb     = fast_fb(data_in);
    assign w_unused = ^{data_in[131:128], data_in[127:80], data_in[15:0]};

    // Map the type word onto a packet kind; unknown types are discarded silently
    always_comb begin
        w_kind_new = KIND_NONE;
        if (w_type == TYPE_TCM) begin
            w_kind_new = KIND_TCM;
        end else if (w_type == TYPE_SEL) begin
            w_kind_new = KIND_SEL;
        end else if (w_type == TYPE_READ) begin
            w_kind_new = KIND_READ;
        end else begin
            w_kind_new = KIND_NONE;
        end
    end

    // RX framing: next state, framing errors and payload-word qualification
    always_comb begin
        w_rx_next   = r_rx_state;
        w_hdr_err   = 1'b0;
        w_pay       = 1'b0;
        w_last      = 1'b0;
        w_enter_pay = 1'b0;
        if (data_in_valid) begin
            case (r_rx_state)
                RX_IDLE: begin
                    if (w_hdr == HDR_HEAD) begin
                        w_rx_next = RX_META;
                    end else if (w_hdr == HDR_BODY || w_hdr == HDR_TAIL) begin
                        w_hdr_err = 1'b1;
                    end else begin
                        w_rx_next = RX_IDLE;
                    end
                end
                RX_META: begin
                    if (w_hdr == HDR_HEAD) begin
                        w_hdr_err = 1'b1;
                        w_rx_next = RX_META;
                    end else if (w_hdr == HDR_BODY) begin
                        w_rx_next = RX_TYPE;
                    end else if (w_hdr == HDR_TAIL) begin
                        w_hdr_err = 1'b1;
                        w_rx_next = RX_IDLE;
                    end else begin
                        w_rx_next = RX_META;
                    end
                end
                RX_TYPE: begin
                    if (w_hdr == HDR_HEAD) begin
                        w_hdr_err = 1'b1;
                        w_rx_next = RX_META;
                    end else if (w_hdr == HDR_BODY) begin
                        if (w_kind_new != KIND_NONE) begin
                            w_rx_next   = RX_PAYLOAD;
                            w_enter_pay = 1'b1;
                        end else begin
                            w_rx_next = RX_DISCARD;
                        end
                    end else if (w_hdr == HDR_TAIL) begin
                        w_hdr_err = 1'b1;
                        w_rx_next = RX_IDLE;
                    end else begin
                        w_rx_next = RX_TYPE;
                    end
                end
                RX_PAYLOAD: begin
                    if (w_hdr == HDR_HEAD) begin
                        w_hdr_err = 1'b1;
                        w_rx_next = RX_META;
                    end else if (w_hdr == HDR_BODY) begin
                        w_pay = 1'b1;
                    end else if (w_hdr == HDR_TAIL) begin
                        w_pay     = 1'b1;
                        w_last    = 1'b1;
                        w_rx_next = RX_IDLE;
                    end else begin
                        w_rx_next = RX_PAYLOAD;
                    end
                end
                RX_DISCARD: begin
                    if (w_hdr == HDR_HEAD) begin
                        w_hdr_err = 1'b1;
                        w_rx_next = RX_META;
                    end else if (w_hdr == HDR_TAIL) begin
                        w_rx_next = RX_IDLE;
                    end else begin
                        w_rx_next = RX_DISCARD;
                    end
                end
                default: w_rx_next = RX_IDLE;
            endcase
        end else begin
            w_rx_next = r_rx_state;
        end
    end

    // Payload actions; the read reply is launched only once the request tail is in
    assign w_in_range  = ((w_fa >> TCM_AW) == 32'd0);
    assign w_wr_go     = w_pay && (r_kind == KIND_TCM) && w_in_range;
    assign w_range_err = w_pay && (r_kind == KIND_TCM) && !w_in_range;
    assign w_sel_go    = w_pay && (r_kind == KIND_SEL) && r_first;
    assign w_rd_go     = w_pay && (r_kind == KIND_READ) && r_first;
    assign w_reply_go  = w_last && (r_kind == KIND_READ) && !w_tx_busy && !r_tx_start;
    assign w_reply_err = w_last && (r_kind == KIND_READ) && (w_tx_busy || r_tx_start);
    assign w_err_any   = w_hdr_err || w_range_err || w_reply_err;

    // RX state, packet kind and first-payload tracking
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_state <= RX_IDLE;
            r_kind     <= KIND_NONE;
            r_first    <= 1'b0;
        end else begin
            r_rx_state <= w_rx_next;
            if (w_enter_pay) begin
                r_kind  <= w_kind_new;
                r_first <= 1'b1;
            end else if (w_pay) begin
                r_first <= 1'b0;
            end
        end
    end

    // Registered TCM, select and read-request outputs plus read data capture
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_en    <= 1'b0;
            r_wr_addr  <= {TCM_AW{1'b0}};
            r_wr_data  <= 32'd0;
            r_rd_en    <= 1'b0;
            r_rd_en_d  <= 1'b0;
            r_rd_addr  <= {TCM_AW{1'b0}};
            r_rd_data  <= 32'd0;
            r_rd_have  <= 1'b0;
            r_conf_sel <= 32'd0;
            r_sel_upd  <= 1'b0;
            r_tx_start <= 1'b0;
        end else begin
            r_wr_en    <= w_wr_go;
            r_rd_en    <= w_rd_go;
            r_rd_en_d  <= r_rd_en;
            r_sel_upd  <= w_sel_go;
            r_tx_start <= w_reply_go;
            if (w_wr_go) begin
                r_wr_addr <= w_fa[TCM_AW-1:0];
                r_wr_data <= w_fb;
            end
            if (w_rd_go) begin
                r_rd_addr <= w_fa[TCM_AW-1:0];
            end
            if (w_sel_go) begin
                r_conf_sel <= w_fa;
            end
            // TCM returns data the cycle after the strobe; a new request invalidates it
            if (r_rd_en_d) begin
                r_rd_data <= tcm_rd_data;
            end
            if (w_rd_go) begin
                r_rd_have <= 1'b0;
            end else if (r_rd_en_d) begin
                r_rd_have <= 1'b1;
            end
        end
    end

    // Saturating statistics counters; coincident error sources count once
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_cnt  <= {CNT_W{1'b0}};
            r_err_cnt <= {CNT_W{1'b0}};
        end else begin
            if (w_wr_go && (r_wr_cnt != {CNT_W{1'b1}})) begin
                r_wr_cnt <= r_wr_cnt + CNT_W'(1);
            end
            if (w_err_any && (r_err_cnt != {CNT_W{1'b1}})) begin
                r_err_cnt <= r_err_cnt + CNT_W'(1);
            end
        end
    end

    fast_reply_tx #(
        .TCM_AW    (TCM_AW),
        .TYPE_READ (TYPE_READ)
    ) u_reply_tx (
        .clk       (clk),
        .reset     (reset),
        .i_start   (r_tx_start),
        .i_addr    (r_rd_addr),
        .i_rd_have (r_rd_have),
        .i_rd_data (r_rd_data),
        .o_busy    (w_tx_busy),
        .o_valid   (data_out_valid),
        .o_data    (data_out)
    );

    assign tcm_wr_en    = r_wr_en;
    assign tcm_wr_addr  = r_wr_addr;
    assign tcm_wr_data  = r_wr_data;
    assign tcm_rd_en    = r_rd_en;
    assign tcm_rd_addr  = r_rd_addr;
    assign conf_sel     = r_conf_sel;
    assign conf_sel_upd = r_sel_upd;
    assign tcm_wr_cnt   = r_wr_cnt;
    assign err_cnt      = r_err_cnt;

endmodule
